// File: rtl/apb_adc_poller.sv
// apb_adc_poller: APB requester that switches the ADC completer on, polls its
// 12-bit conversion result every `period` cycles and forwards each result to
// the PID datapath on a valid/ready stream.
//
// Ports:
//   PCLK, PRESET          clock, asynchronous active-high reset
//   enable                level: 1 = run polling, 0 = switch sampling off and idle
//   period                cycles between read SETUP phases (0 and 1 act as 2)
//   err_clr               one-cycle pulse clearing err and overrun
//   PSEL/PENABLE/PWRITE   APB requester controls
//   PADDR/PWDATA          APB address / write data
//   PRDATA/PREADY/PSLVERR APB completer response
//   sample_data/_valid    stream payload / valid toward the PID datapath
//   sample_ready          stream ready from the PID datapath
//   busy                  FSM not in IDLE
//   err                   sticky: a transfer completed with PSLVERR
//   overrun               sticky: a poll was skipped or a result dropped
module apb_adc_poller #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned PERIOD_W  = 16
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                err_clr,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [31:0]         PADDR,
    output logic [31:0]         PWDATA,
    input  logic [31:0]         PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR,
    output logic [11:0]         sample_data,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                busy,
    output logic                err,
    output logic                overrun
);

    localparam int unsigned SAMPLE_W = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ON_SETUP,
        S_ON_ACCESS,
        S_WAIT,
        S_RD_SETUP,
        S_RD_ACCESS,
        S_OFF_SETUP,
        S_OFF_ACCESS
    } state_e;

    state_e state_q, state_d;

    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [31:0]         paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic                busy_q, busy_d;

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] sample_data_q, sample_data_d;
    logic                sample_valid_q, sample_valid_d;
    logic                err_q, err_d;
    logic                overrun_q, overrun_d;

    logic                unused_prdata_c;
    logic                cnt_zero_c;
    logic                xfer_done_c;
    logic                rd_done_c;
    logic                skip_c;
    logic [PERIOD_W-1:0] reload_c;

    assign unused_prdata_c = ^PRDATA[31:SAMPLE_W];

    assign cnt_zero_c  = (cnt_q == '0);
    assign xfer_done_c = PREADY && (state_q == S_ON_ACCESS || state_q == S_RD_ACCESS ||
                                    state_q == S_OFF_ACCESS);
    assign rd_done_c   = PREADY && (state_q == S_RD_ACCESS);
    // Period expired while the previous sample is still unaccepted: skip this poll.
    assign skip_c      = (state_q == S_WAIT) && enable && cnt_zero_c && sample_valid_q;
    assign reload_c    = (period <= PERIOD_W'(1)) ? PERIOD_W'(1) : (period - PERIOD_W'(1));

    // State register
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a started transfer always runs to completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (enable) state_d = S_ON_SETUP;
            S_ON_SETUP:   state_d = S_ON_ACCESS;
            S_ON_ACCESS:  if (PREADY) state_d = enable ? S_RD_SETUP : S_OFF_SETUP;
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_OFF_SETUP;
                end else if (cnt_zero_c && !sample_valid_q) begin
                    state_d = S_RD_SETUP;
                end
            end
            S_RD_SETUP:   state_d = S_RD_ACCESS;
            S_RD_ACCESS: begin
                if (PREADY) begin
                    if (!enable) begin
                        state_d = S_OFF_SETUP;
                    end else if (cnt_zero_c) begin
                        state_d = S_RD_SETUP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_OFF_SETUP:  state_d = S_OFF_ACCESS;
            S_OFF_ACCESS: if (PREADY) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Output decode of the next state; address/data only change on SETUP entry.
    always_comb begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        busy_d    = (state_d != S_IDLE);
        unique case (state_d)
            S_ON_SETUP: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = BASE_ADDR;
                pwdata_d = 32'h0000_0001;
            end
            S_RD_SETUP: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b0;
                paddr_d  = BASE_ADDR;
            end
            S_OFF_SETUP: begin
                psel_d   = 1'b1;
                pwrite_d = 1'b1;
                paddr_d  = BASE_ADDR;
                pwdata_d = 32'h0000_0000;
            end
            S_ON_ACCESS, S_RD_ACCESS, S_OFF_ACCESS: begin
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // Period counter, sample stream and sticky status next-state
    always_comb begin
        logic rd_ok;
        logic drop;
        logic load;
        cnt_d          = cnt_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        err_d          = err_q;
        overrun_d      = overrun_q;

        if ((state_d == S_RD_SETUP) || skip_c) begin
            cnt_d = reload_c;
        end else if (!cnt_zero_c) begin
            cnt_d = cnt_q - PERIOD_W'(1);
        end

        // A read landing while an unaccepted sample is held is dropped, so the
        // held sample is never overwritten.
        rd_ok = rd_done_c && !PSLVERR;
        drop  = rd_ok && sample_valid_q && !sample_ready;
        load  = rd_ok && !drop;

        if (load) begin
            sample_valid_d = 1'b1;
            sample_data_d  = PRDATA[SAMPLE_W-1:0];
        end else if (sample_valid_q && sample_ready) begin
            sample_valid_d = 1'b0;
        end

        if (xfer_done_c && PSLVERR) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        if (skip_c || drop) begin
            overrun_d = 1'b1;
        end else if (err_clr) begin
            overrun_d = 1'b0;
        end
    end

    // Registered outputs and datapath
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            psel_q         <= 1'b0;
            penable_q      <= 1'b0;
            pwrite_q       <= 1'b0;
            paddr_q        <= '0;
            pwdata_q       <= '0;
            busy_q         <= 1'b0;
            cnt_q          <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            err_q          <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            psel_q         <= psel_d;
            penable_q      <= penable_d;
            pwrite_q       <= pwrite_d;
            paddr_q        <= paddr_d;
            pwdata_q       <= pwdata_d;
            busy_q         <= busy_d;
            cnt_q          <= cnt_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            err_q          <= err_d;
            overrun_q      <= overrun_d;
        end
    end

    assign PSEL         = psel_q;
    assign PENABLE      = penable_q;
    assign PWRITE       = pwrite_q;
    assign PADDR        = paddr_q;
    assign PWDATA       = pwdata_q;
    assign busy         = busy_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign err          = err_q;
    assign overrun      = overrun_q;

endmodule
